// File: rtl/adc_mkid_pkg.sv
// Shared types and helpers for the MKID ADC snapshot capture block.
// Holds the capture FSM states and the 4-lane sample-word packing.
package adc_mkid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } snap_state_e;

    localparam int NUM_LANES = 4;
    localparam int SAMPLE_W  = 12;

    // Stored word layout is {q3..q0, i3..i0}, lane 0 in the low bits of each half.
    function automatic logic [2*NUM_LANES*SAMPLE_W-1:0] pack_word(
        input logic [NUM_LANES*SAMPLE_W-1:0] lanes_q,
        input logic [NUM_LANES*SAMPLE_W-1:0] lanes_i
    );
        return {lanes_q, lanes_i};
    endfunction

endpackage

// File: rtl/snap_sdp_ram.sv
// Simple dual-port RAM: one write port, one read-first synchronous read port.
// Written to infer a block RAM with a resettable output register.
module snap_sdp_ram #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 96
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking update means a same-cycle read below sees the old contents (read-first).
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/adc_mkid_snap_capture.sv
// Triggered snapshot buffer for the MKID 4x ADC stream in the adc_clk domain.
// Arm, wait for user_sync or soft_trig, then store capture_len consecutive words.
module adc_mkid_snap_capture
    import adc_mkid_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic                          adc_clk,
    input  logic                          adc_rst_n,
    input  logic [4*DATA_W-1:0]           data_i,
    input  logic [4*DATA_W-1:0]           data_q,
    input  logic                          user_sync,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          trig_sel,
    input  logic                          soft_trig,
    input  logic [ADDR_W-1:0]             capture_len,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W:0]               words_captured,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [8*DATA_W-1:0]           rd_data
);

    localparam int              WORD_W   = 2 * NUM_LANES * DATA_W;
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    snap_state_e       r_state;
    snap_state_e       w_next_state;
    logic              r_trig_sel;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W:0]   w_words_inc;
    logic              w_trig;
    logic              w_arm_ok;
    logic              w_last;
    logic              w_wr_en;
    logic [WORD_W-1:0] w_wr_data;

    // Reset asserts immediately but releases two edges later, aligned to adc_clk.
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_len       = (r_len == '0) ? FULL_LEN : {1'b0, r_len};
    assign w_words_inc = r_words + ONE;
    assign w_trig      = r_trig_sel ? soft_trig : user_sync;
    assign w_arm_ok    = arm && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last      = (w_words_inc == w_len);
    assign w_wr_en     = !abort && ((r_state == ST_ARMED && w_trig) || r_state == ST_CAPTURE);

    always_ff @(posedge adc_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (arm)    w_next_state = ST_ARMED;
            ST_ARMED:   if (w_trig) w_next_state = w_last ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: if (w_last) w_next_state = ST_DONE;
            ST_DONE:    if (arm)    w_next_state = ST_ARMED;
            default:                w_next_state = ST_IDLE;
        endcase
        if (abort) begin
            w_next_state = ST_IDLE;
        end
    end

    always_comb begin
        busy = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
        done = (r_state == ST_DONE);
    end

    // Arm latches the capture settings; the write count doubles as the write address.
    always_ff @(posedge adc_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_trig_sel <= 1'b0;
            r_len      <= '0;
            r_words    <= '0;
        end else if (w_arm_ok) begin
            r_trig_sel <= trig_sel;
            r_len      <= capture_len;
            r_words    <= '0;
        end else if (w_wr_en) begin
            r_words    <= w_words_inc;
        end
    end

    assign words_captured = r_words;

    generate
        if (DATA_W == SAMPLE_W) begin : g_pack
            assign w_wr_data = pack_word(data_q, data_i);
        end else begin : g_concat
            assign w_wr_data = {data_q, data_i};
        end
    endgenerate

    snap_sdp_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .i_clk     (adc_clk),
        .i_rst_n   (w_rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_words[ADDR_W-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

endmodule
